// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter.
// cdb_bus is the result record every execution unit places on the CDB.
package cdb_arbiter_pkg;

    localparam int CDB_TAG_W   = 5;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_NUM_SRC = 4;
    localparam int CDB_QDEPTH  = 2;

    // Source index assignment on the shared bus
    localparam int SRC_INT  = 0;
    localparam int SRC_MULT = 1;
    localparam int SRC_DIV  = 2;
    localparam int SRC_LS   = 3;

    typedef struct packed {
        logic                  cdb_valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic                  branch;
        logic                  branch_taken;
    } cdb_bus;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-source holding FIFO for CDB results. A push while full is
// refused; flush empties the queue and discards any push in that cycle.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int QDEPTH = CDB_QDEPTH
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  cdb_bus push_data,
    input  logic   pop,
    output cdb_bus head,
    output logic   empty,
    output logic   full
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    cdb_bus         mem [QDEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(QDEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Entry storage: written on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; push and pop together keep count steady
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: every execution unit has a holding FIFO and a
// round-robin arbiter drains one result per cycle onto the registered CDB.
// Optional build macro CDB_PRIO_MULT_EN gives source MULT_IDX fixed priority
// without advancing the round-robin pointer.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC  = CDB_NUM_SRC,
    parameter int QDEPTH   = CDB_QDEPTH,
    parameter int MULT_IDX = SRC_MULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  cdb_bus [NUM_SRC-1:0]       src_cdb,
    output logic   [NUM_SRC-1:0]       src_ready,
    output cdb_bus                     cdb_out,
    output logic [$clog2(NUM_SRC)-1:0] cdb_src,
    output logic                       overflow
);

    localparam int SW = $clog2(NUM_SRC);

`ifdef CDB_PRIO_MULT_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    cdb_bus              head [NUM_SRC];
    logic [NUM_SRC-1:0]  empty;
    logic [NUM_SRC-1:0]  full;
    logic [NUM_SRC-1:0]  push;
    logic [NUM_SRC-1:0]  pop;
    logic [SW-1:0]       rr_ptr;
    logic [SW-1:0]       win_idx;
    logic [SW-1:0]       next_ptr;
    logic                have_win;

    assign src_ready = ~full;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        assign push[i] = src_cdb[i].cdb_valid;
        assign pop[i]  = have_win && (win_idx == SW'(i));

        cdb_src_fifo #(
            .QDEPTH(QDEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .push      (push[i]),
            .push_data (src_cdb[i]),
            .pop       (pop[i]),
            .head      (head[i]),
            .empty     (empty[i]),
            .full      (full[i])
        );
    end

    // Pick the first non-empty FIFO at or after the pointer, or the multiplier if prioritised
    always_comb begin
        have_win = 1'b0;
        win_idx  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int cand;
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!have_win && !empty[cand]) begin
                have_win = 1'b1;
                win_idx  = SW'(cand);
            end
        end
        next_ptr = (win_idx == SW'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
        if (PRIO_EN && !empty[MULT_IDX]) begin
            have_win = 1'b1;
            win_idx  = SW'(MULT_IDX);
            next_ptr = rr_ptr;
        end
        if (!have_win) begin
            next_ptr = rr_ptr;
        end
    end

    // Register the winning head onto the CDB and track the sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_out  <= '0;
            cdb_src  <= '0;
            rr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= overflow | (|(push & full));
            if (flush) begin
                cdb_out <= '0;
            end else if (have_win) begin
                cdb_out           <= head[win_idx];
                cdb_out.cdb_valid <= 1'b1;
                cdb_src           <= win_idx;
                rr_ptr            <= next_ptr;
            end else begin
                cdb_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build, pure round-robin).
// A cycle-by-cycle vector table covers broadcast order, fairness and
// back-pressure; hand sequences cover single-source latency, flush and reset.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic                clk;
    logic                rst;
    logic                flush;
    cdb_bus [3:0]        src_cdb;
    logic   [3:0]        src_ready;
    cdb_bus              cdb_out;
    logic   [1:0]        cdb_src;
    logic                overflow;

    int n_vec;
    int n_miss;

    typedef struct {
        logic [3:0] vmask;
        int         t0;
        int         t1;
        int         t2;
        int         t3;
        logic       exp_valid;
        int         exp_tag;
        int         exp_src;
        logic [3:0] exp_ready;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [24];

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_cdb   (src_cdb),
        .src_ready (src_ready),
        .cdb_out   (cdb_out),
        .cdb_src   (cdb_src),
        .overflow  (overflow)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input int src, input int tag);
        return 32'hC0DE_0000 | (32'(src) << 8) | 32'(tag);
    endfunction

    function automatic cdb_bus bus_of(input logic valid, input int src, input int tag);
        cdb_bus b;
        logic [4:0] t;
        t = 5'(tag);
        b = '0;
        if (valid) begin
            b.cdb_valid    = 1'b1;
            b.tag          = t;
            b.data         = data_of(src, tag);
            b.branch       = t[0];
            b.branch_taken = t[1];
        end
        return b;
    endfunction

    function automatic vec_t mk(input logic [3:0] vm, input int t0, input int t1,
                                input int t2, input int t3, input logic ev,
                                input int etag, input int esrc,
                                input logic [3:0] erdy, input logic eovf);
        vec_t v;
        v.vmask = vm; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
        v.exp_valid = ev; v.exp_tag = etag; v.exp_src = esrc;
        v.exp_ready = erdy; v.exp_ovf = eovf;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in and settle just after the edge
    task automatic apply_stimulus(input logic [3:0] vm, input int t0, input int t1,
                                  input int t2, input int t3, input logic fl);
        src_cdb[SRC_INT]  = bus_of(vm[0], SRC_INT,  t0);
        src_cdb[SRC_MULT] = bus_of(vm[1], SRC_MULT, t1);
        src_cdb[SRC_DIV]  = bus_of(vm[2], SRC_DIV,  t2);
        src_cdb[SRC_LS]   = bus_of(vm[3], SRC_LS,   t3);
        flush = fl;
        @(posedge clk);
        #1;
        src_cdb = '0;
        flush   = 1'b0;
    endtask

    task automatic check_bcast(input string name, input logic ev, input int etag,
                               input int esrc);
        check_output({name, ".cdb_out"}, 64'(cdb_out), 64'(bus_of(ev, esrc, etag)));
        if (ev) begin
            check_output({name, ".cdb_src"}, 64'(cdb_src), 64'(esrc));
        end
    endtask

    initial begin
        cdb_bus hand;
        n_vec   = 0;
        n_miss  = 0;
        rst     = 1'b1;
        flush   = 1'b0;
        src_cdb = '0;

        // Broadcast order, alternating fairness, back-pressure and overflow
        vecs[0]  = mk(4'b1111,  1,  2, 3, 4, 1'b0,  0, 0, 4'b1111, 1'b0);
        vecs[1]  = mk(4'b0000,  0,  0, 0, 0, 1'b1,  1, 0, 4'b1111, 1'b0);
        vecs[2]  = mk(4'b0000,  0,  0, 0, 0, 1'b1,  2, 1, 4'b1111, 1'b0);
        vecs[3]  = mk(4'b0000,  0,  0, 0, 0, 1'b1,  3, 2, 4'b1111, 1'b0);
        vecs[4]  = mk(4'b0000,  0,  0, 0, 0, 1'b1,  4, 3, 4'b1111, 1'b0);
        vecs[5]  = mk(4'b0000,  0,  0, 0, 0, 1'b0,  0, 0, 4'b1111, 1'b0);
        vecs[6]  = mk(4'b0011, 10, 11, 0, 0, 1'b0,  0, 0, 4'b1111, 1'b0);
        vecs[7]  = mk(4'b0001, 12,  0, 0, 0, 1'b1, 10, 0, 4'b1111, 1'b0);
        vecs[8]  = mk(4'b0010,  0, 13, 0, 0, 1'b1, 11, 1, 4'b1111, 1'b0);
        vecs[9]  = mk(4'b0001, 14,  0, 0, 0, 1'b1, 12, 0, 4'b1111, 1'b0);
        vecs[10] = mk(4'b0000,  0,  0, 0, 0, 1'b1, 13, 1, 4'b1111, 1'b0);
        vecs[11] = mk(4'b0000,  0,  0, 0, 0, 1'b1, 14, 0, 4'b1111, 1'b0);
        vecs[12] = mk(4'b0000,  0,  0, 0, 0, 1'b0,  0, 0, 4'b1111, 1'b0);
        vecs[13] = mk(4'b1000,  0,  0, 0,30, 1'b0,  0, 0, 4'b1111, 1'b0);
        vecs[14] = mk(4'b0000,  0,  0, 0, 0, 1'b1, 30, 3, 4'b1111, 1'b0);
        vecs[15] = mk(4'b0111, 20, 21, 7, 0, 1'b0,  0, 0, 4'b1111, 1'b0);
        vecs[16] = mk(4'b0111, 22, 23, 8, 0, 1'b1, 20, 0, 4'b1001, 1'b0);
        vecs[17] = mk(4'b0101, 24,  0, 9, 0, 1'b1, 21, 1, 4'b1010, 1'b1);
        vecs[18] = mk(4'b0000,  0,  0, 0, 0, 1'b1,  7, 2, 4'b1110, 1'b1);
        vecs[19] = mk(4'b0000,  0,  0, 0, 0, 1'b1, 22, 0, 4'b1111, 1'b1);
        vecs[20] = mk(4'b0000,  0,  0, 0, 0, 1'b1, 23, 1, 4'b1111, 1'b1);
        vecs[21] = mk(4'b0000,  0,  0, 0, 0, 1'b1,  8, 2, 4'b1111, 1'b1);
        vecs[22] = mk(4'b0000,  0,  0, 0, 0, 1'b1, 24, 0, 4'b1111, 1'b1);
        vecs[23] = mk(4'b0000,  0,  0, 0, 0, 1'b0,  0, 0, 4'b1111, 1'b1);

        #1;
        check_output("reset.cdb_out",   64'(cdb_out),   64'd0);
        check_output("reset.cdb_src",   64'(cdb_src),   64'd0);
        check_output("reset.src_ready", 64'(src_ready), 64'hF);
        check_output("reset.overflow",  64'(overflow),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            apply_stimulus(vecs[i].vmask, vecs[i].t0, vecs[i].t1, vecs[i].t2,
                           vecs[i].t3, 1'b0);
            check_bcast($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_tag,
                        vecs[i].exp_src);
            check_output($sformatf("vec%0d.src_ready", i), 64'(src_ready),
                         64'(vecs[i].exp_ready));
            check_output($sformatf("vec%0d.overflow", i), 64'(overflow),
                         64'(vecs[i].exp_ovf));
        end

        // Single int result: broadcast one edge after the FIFO write, then idle
        $display("[TB] single-source latency");
        hand              = '0;
        hand.cdb_valid    = 1'b1;
        hand.tag          = 5'd5;
        hand.data         = 32'h0000_1234;
        hand.branch       = 1'b1;
        src_cdb[SRC_INT]  = hand;
        @(posedge clk);
        #1;
        src_cdb = '0;
        check_output("single.edge0", 64'(cdb_out.cdb_valid), 64'd0);
        apply_stimulus(4'b0000, 0, 0, 0, 0, 1'b0);
        check_output("single.cdb_out", 64'(cdb_out), 64'(hand));
        check_output("single.cdb_src", 64'(cdb_src), 64'd0);
        apply_stimulus(4'b0000, 0, 0, 0, 0, 1'b0);
        check_output("single.idle", 64'(cdb_out.cdb_valid), 64'd0);

        // Flush squashes queued entries and the push in the flush cycle
        $display("[TB] flush");
        apply_stimulus(4'b0111, 40, 41, 42, 0, 1'b0);
        check_output("flush.pre", 64'(cdb_out.cdb_valid), 64'd0);
        apply_stimulus(4'b1000, 0, 0, 0, 43, 1'b1);
        check_output("flush.cdb_out",   64'(cdb_out),   64'd0);
        check_output("flush.src_ready", 64'(src_ready), 64'hF);
        check_output("flush.overflow",  64'(overflow),  64'd1);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(4'b0000, 0, 0, 0, 0, 1'b0);
            check_output($sformatf("flush.after%0d", i), 64'(cdb_out.cdb_valid), 64'd0);
        end

        // Asynchronous reset with two entries queued
        $display("[TB] reset mid-traffic");
        apply_stimulus(4'b0011, 50, 51, 0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_output("rstmid.cdb_valid", 64'(cdb_out.cdb_valid), 64'd0);
        check_output("rstmid.src_ready", 64'(src_ready),         64'hF);
        check_output("rstmid.overflow",  64'(overflow),          64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(4'b0000, 0, 0, 0, 0, 1'b0);
            check_output($sformatf("rstmid.lost%0d", i), 64'(cdb_out.cdb_valid), 64'd0);
        end
        apply_stimulus(4'b1001, 61, 0, 0, 60, 1'b0);
        check_output("rstptr.pre", 64'(cdb_out.cdb_valid), 64'd0);
        apply_stimulus(4'b0000, 0, 0, 0, 0, 1'b0);
        check_bcast("rstptr.first", 1'b1, 61, 0);
        apply_stimulus(4'b0000, 0, 0, 0, 0, 1'b0);
        check_bcast("rstptr.second", 1'b1, 60, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
